// File: rtl/csr_pkg.sv
// Machine-mode CSR addresses, bit positions, write masks and the bus request/response
// structs shared by the CSR file, its cycle counter and the bus interface.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIP_MTIP     = 7;

  localparam logic [31:0] MCAUSE_MTI   = 32'h8000_0007;
  localparam logic [31:0] MTI_VEC_OFF  = 32'd28;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0080;
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_WMASK  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        csr_rd;
    logic        csr_wr;
    logic        is_mret;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] pc;
  } csr_req_t;

  typedef struct packed {
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc;
  } csr_rsp_t;

endpackage

// File: rtl/csr_if.sv
// Controller-to-CSR-file bus: request from decode/control, read data and redirect back.
interface csr_if;
  import csr_pkg::*;

  csr_req_t req;
  csr_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/csr_cycle_counter.sv
// Free-running 64-bit cycle counter; each half can be loaded independently.
module csr_cycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_lo,
  input  logic        ld_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  logic [31:0] lo, hi;
  logic        carry;

  // Carry comes from the natural increment even when the low half is being loaded.
  assign carry = &lo;
  assign cnt   = {hi, lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo <= '0;
      hi <= '0;
    end else begin
      lo <= ld_lo ? wdata : lo + 32'd1;
      hi <= ld_hi ? wdata : hi + {31'd0, carry};
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational reads, CSRRW writes, timer-interrupt trap and MRET
// redirect, plus the 64-bit mcycle counter.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic timer_irq,
  csr_if.slave bus
);

  logic [31:0] mstatus, mie, mip, mtvec, mepc, mcause;
  logic [31:0] rdata, trap_base;
  logic [63:0] mcycle;
  logic        irq, trap, wr, ld_lo, ld_hi;
  csr_rsp_t    rsp;

  assign irq   = mstatus[MSTATUS_MIE] & mie[MIE_MTIE] & mip[MIP_MTIP];
  // MRET outranks a pending interrupt; the trapped instruction does not retire its write.
  assign trap  = irq & ~bus.req.is_mret;
  assign wr    = bus.req.csr_wr & ~trap;
  assign ld_lo = wr && (bus.req.csr_addr == CSR_MCYCLE);
  assign ld_hi = wr && (bus.req.csr_addr == CSR_MCYCLEH);

  csr_cycle_counter u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_lo (ld_lo),
    .ld_hi (ld_hi),
    .wdata (bus.req.csr_wdata),
    .cnt   (mcycle)
  );

  always_comb begin
    rdata = '0;
    case (bus.req.csr_addr)
      CSR_MSTATUS: rdata = mstatus;
      CSR_MIE:     rdata = mie;
      CSR_MTVEC:   rdata = mtvec;
      CSR_MEPC:    rdata = mepc;
      CSR_MCAUSE:  rdata = mcause;
      CSR_MIP:     rdata = mip;
      CSR_MCYCLE:  rdata = mcycle[31:0];
      CSR_MCYCLEH: rdata = mcycle[63:32];
      CSR_MHARTID: rdata = HART_ID;
      default:     rdata = '0;
    endcase
  end

  assign trap_base = mtvec & MEPC_WMASK;

  always_comb begin
    rsp           = '0;
    rsp.csr_rdata = bus.req.csr_rd ? rdata : '0;
    if (bus.req.is_mret) begin
      rsp.epc_taken = 1'b1;
      rsp.epc       = mepc;
    end else if (trap) begin
      rsp.epc_taken = 1'b1;
      rsp.epc       = mtvec[0] ? trap_base + MTI_VEC_OFF : trap_base;
    end
  end

  assign bus.rsp = rsp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus <= '0;
      mie     <= '0;
      mip     <= '0;
      mtvec   <= MTVEC_RST & MTVEC_WMASK;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      mip <= timer_irq ? (32'd1 << MIP_MTIP) : '0;
      if (trap) begin
        mepc                  <= bus.req.pc & MEPC_WMASK;
        mcause                <= MCAUSE_MTI;
        mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
        mstatus[MSTATUS_MIE]  <= 1'b0;
      end else if (bus.req.is_mret) begin
        mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
        mstatus[MSTATUS_MPIE] <= 1'b1;
      end else if (wr) begin
        case (bus.req.csr_addr)
          CSR_MSTATUS: mstatus <= bus.req.csr_wdata & MSTATUS_WMASK;
          CSR_MIE:     mie     <= bus.req.csr_wdata & MIE_WMASK;
          CSR_MTVEC:   mtvec   <= bus.req.csr_wdata & MTVEC_WMASK;
          CSR_MEPC:    mepc    <= bus.req.csr_wdata & MEPC_WMASK;
          CSR_MCAUSE:  mcause  <= bus.req.csr_wdata & MCAUSE_WMASK;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset values, write masks, trap/MRET redirect, mcycle carry,
// and asynchronous reset in the middle of a trap.
module tb_csr_file;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic timer_irq;
  int   n_chk = 0;
  int   n_err = 0;

  csr_if bus ();

  csr_file #(
    .MTVEC_RST (32'h0000_0100),
    .HART_ID   (32'h0000_0005)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .timer_irq (timer_irq),
    .bus       (bus.slave)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus.req.csr_rd   = 1'b1;
    bus.req.csr_addr = addr;
    #1;
    chk(tag, bus.rsp.csr_rdata, exp);
  endtask

  task automatic wr_csr(input logic [11:0] addr, input logic [31:0] data);
    bus.req.csr_wr    = 1'b1;
    bus.req.csr_rd    = 1'b1;
    bus.req.csr_addr  = addr;
    bus.req.csr_wdata = data;
    @(negedge clk);
    bus.req.csr_wr    = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    timer_irq = 1'b0;
    bus.req   = '0;
    #2;
    chk("rst_rdata", bus.rsp.csr_rdata, 32'h0);
    chk("rst_taken", {31'd0, bus.rsp.epc_taken}, 32'h0);
    chk("rst_epc", bus.rsp.epc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("mtvec_rst", CSR_MTVEC, 32'h0000_0100);
    chk("idle_taken", {31'd0, bus.rsp.epc_taken}, 32'h0);
    rd_chk("mhartid", CSR_MHARTID, 32'h0000_0005);
    rd_chk("unimpl", 12'h123, 32'h0);
    bus.req.csr_rd = 1'b0;
    #1;
    chk("rd_off", bus.rsp.csr_rdata, 32'h0);
    @(negedge clk);

    // mstatus mask, same-cycle old value, read-only mip
    bus.req.csr_wr = 1'b1; bus.req.csr_rd = 1'b1;
    bus.req.csr_addr = CSR_MSTATUS; bus.req.csr_wdata = 32'hFFFF_FFFF;
    #1;
    chk("wr_old_val", bus.rsp.csr_rdata, 32'h0);
    @(negedge clk);
    bus.req.csr_wr = 1'b0;
    rd_chk("mstatus_mask", CSR_MSTATUS, 32'h0000_0088);
    @(negedge clk);
    wr_csr(CSR_MIP, 32'hFFFF_FFFF);
    rd_chk("mip_ro", CSR_MIP, 32'h0);
    wr_csr(CSR_MTVEC, 32'h0000_0203);
    rd_chk("mtvec_bit1", CSR_MTVEC, 32'h0000_0201);
    wr_csr(CSR_MIE, 32'hFFFF_FFFF);
    rd_chk("mie_mask", CSR_MIE, 32'h0000_0080);

    // timer trap with a concurrent mie write
    @(negedge clk);
    timer_irq = 1'b1;
    #1;
    chk("irq_unreg_taken", {31'd0, bus.rsp.epc_taken}, 32'h0);
    @(negedge clk);
    bus.req.pc = 32'h0000_0040;
    bus.req.csr_wr = 1'b1; bus.req.csr_rd = 1'b1;
    bus.req.csr_addr = CSR_MIE; bus.req.csr_wdata = 32'h0;
    #1;
    chk("trap_taken", {31'd0, bus.rsp.epc_taken}, 32'h1);
    chk("trap_epc", bus.rsp.epc, 32'h0000_021C);
    @(negedge clk);
    bus.req.csr_wr = 1'b0;
    #1;
    chk("no_retrap", {31'd0, bus.rsp.epc_taken}, 32'h0);
    rd_chk("trap_mepc", CSR_MEPC, 32'h0000_0040);
    rd_chk("trap_mcause", CSR_MCAUSE, 32'h8000_0007);
    rd_chk("trap_mstatus", CSR_MSTATUS, 32'h0000_0080);
    rd_chk("mie_suppressed", CSR_MIE, 32'h0000_0080);
    rd_chk("mip_mtip", CSR_MIP, 32'h0000_0080);

    // MRET beats the pending interrupt, then the interrupt retakes
    @(negedge clk);
    bus.req.is_mret = 1'b1;
    bus.req.csr_rd  = 1'b0;
    #1;
    chk("mret_taken", {31'd0, bus.rsp.epc_taken}, 32'h1);
    chk("mret_epc", bus.rsp.epc, 32'h0000_0040);
    @(negedge clk);
    bus.req.is_mret = 1'b0;
    bus.req.pc = 32'h0000_0080;
    #1;
    chk("retrap_taken", {31'd0, bus.rsp.epc_taken}, 32'h1);
    chk("retrap_epc", bus.rsp.epc, 32'h0000_021C);
    rd_chk("mret_mstatus", CSR_MSTATUS, 32'h0000_0088);
    @(negedge clk);
    timer_irq = 1'b0;
    rd_chk("retrap_mepc", CSR_MEPC, 32'h0000_0080);
    rd_chk("retrap_mstatus", CSR_MSTATUS, 32'h0000_0080);
    @(negedge clk);

    // mcycle carry into mcycleh
    wr_csr(CSR_MCYCLEH, 32'h0);
    wr_csr(CSR_MCYCLE, 32'hFFFF_FFFF);
    rd_chk("mcycle_load", CSR_MCYCLE, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    rd_chk("mcycle_wrap", CSR_MCYCLE, 32'h0000_0001);
    rd_chk("mcycleh_carry", CSR_MCYCLEH, 32'h0000_0001);
    @(negedge clk);
    wr_csr(CSR_MCYCLEH, 32'h0000_ABCD);
    rd_chk("mcycleh_load", CSR_MCYCLEH, 32'h0000_ABCD);

    // asynchronous reset while a trap is being presented
    @(negedge clk);
    wr_csr(CSR_MSTATUS, 32'h0000_0008);
    timer_irq = 1'b1;
    @(negedge clk);
    bus.req.pc = 32'h0000_0100;
    bus.req.csr_rd = 1'b0;
    #1;
    chk("mid_trap_taken", {31'd0, bus.rsp.epc_taken}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_taken_async", {31'd0, bus.rsp.epc_taken}, 32'h0);
    rd_chk("rst_mepc", CSR_MEPC, 32'h0);
    rd_chk("rst_mstatus", CSR_MSTATUS, 32'h0);
    rd_chk("rst_mie", CSR_MIE, 32'h0);
    rd_chk("rst_mcause", CSR_MCAUSE, 32'h0);
    rd_chk("rst_mtvec", CSR_MTVEC, 32'h0000_0100);
    timer_irq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("post_rst_mepc", CSR_MEPC, 32'h0);
    rd_chk("post_rst_mip", CSR_MIP, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
